// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port register file with write bypass and pending-write scoreboard
module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  pend_q;
  logic [DEPTH-1:0]  pend_d;

  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs_d[i] = '0;
      pend_d = '0;
    end else begin
      // port 1 is applied last so it wins a same-address collision
      if (we0) regs_d[waddr0] = wdata0;
      if (we1) regs_d[waddr1] = wdata1;
      // clear before set: a newly issued producer outranks the retiring write
      if (we1)    pend_d[waddr1]  = 1'b0;
      if (sb_set) pend_d[sb_addr] = 1'b1;
      if (ZERO_REG != 0) begin
        regs_d[0] = '0;
        pend_d[0] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    regs_q <= regs_d;
    pend_q <= pend_d;
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    logic              bz;
    logic              hit1;
    logic              hit0;

    assign ra   = raddr[k*ADDR_W +: ADDR_W];
    assign hit1 = we1 && (waddr1 == ra);
    assign hit0 = we0 && (waddr0 == ra);

    always_comb begin
      rd = regs_q[ra];
      if (hit1)      rd = wdata1;
      else if (hit0) rd = wdata0;
      bz = pend_q[ra] && !hit1;
      if ((ZERO_REG != 0) && (ra == '0)) begin
        rd = '0;
        bz = 1'b0;
      end
    end

    assign rdata[k*DATA_W +: DATA_W] = rd;
    assign rbusy[k]                  = bz;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - scoreboard bench for reg_file_mp across three parameter sets
module tb_reg_file_mp;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [63:0] exp_d [$];
  logic [3:0]  exp_b [$];

  // instance A: defaults, zero register enabled
  logic        a_we0, a_we1, a_sb_set;
  logic [4:0]  a_waddr0, a_waddr1, a_sb_addr;
  logic [31:0] a_wdata0, a_wdata1;
  logic [9:0]  a_raddr;
  logic [63:0] a_rdata;
  logic [1:0]  a_rbusy;

  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) u_a (
    .clk(clk), .rst(rst),
    .we0(a_we0), .waddr0(a_waddr0), .wdata0(a_wdata0),
    .we1(a_we1), .waddr1(a_waddr1), .wdata1(a_wdata1),
    .sb_set(a_sb_set), .sb_addr(a_sb_addr),
    .raddr(a_raddr), .rdata(a_rdata), .rbusy(a_rbusy)
  );

  // instance B: register 0 is an ordinary register
  logic        b_we1, b_sb_set;
  logic [4:0]  b_waddr1, b_sb_addr;
  logic [31:0] b_wdata1;
  logic [9:0]  b_raddr;
  logic [63:0] b_rdata;
  logic [1:0]  b_rbusy;

  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(0)) u_b (
    .clk(clk), .rst(rst),
    .we0(1'b0), .waddr0(5'd0), .wdata0(32'd0),
    .we1(b_we1), .waddr1(b_waddr1), .wdata1(b_wdata1),
    .sb_set(b_sb_set), .sb_addr(b_sb_addr),
    .raddr(b_raddr), .rdata(b_rdata), .rbusy(b_rbusy)
  );

  // instance C: four wide read ports
  logic        c_we0, c_we1, c_sb_set;
  logic [3:0]  c_waddr0, c_waddr1, c_sb_addr;
  logic [63:0] c_wdata0, c_wdata1;
  logic [15:0] c_raddr;
  logic [255:0] c_rdata;
  logic [3:0]  c_rbusy;

  reg_file_mp #(.DATA_W(64), .ADDR_W(4), .NUM_RD(4), .ZERO_REG(1)) u_c (
    .clk(clk), .rst(rst),
    .we0(c_we0), .waddr0(c_waddr0), .wdata0(c_wdata0),
    .we1(c_we1), .waddr1(c_waddr1), .wdata1(c_wdata1),
    .sb_set(c_sb_set), .sb_addr(c_sb_addr),
    .raddr(c_raddr), .rdata(c_rdata), .rbusy(c_rbusy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a;
    a_we0 = 0; a_we1 = 0; a_sb_set = 0;
    a_waddr0 = 0; a_waddr1 = 0; a_sb_addr = 0;
    a_wdata0 = 0; a_wdata1 = 0;
  endtask

  // push expected data for both A ports plus busy, then compare
  task automatic check_a(input string name, input logic [31:0] e0, input logic [31:0] e1,
                         input logic [1:0] eb);
    logic [63:0] d;
    logic [3:0]  b;
    exp_d.push_back({32'd0, e0});
    exp_d.push_back({32'd0, e1});
    exp_b.push_back({2'b00, eb});
    #1;
    for (int p = 0; p < 2; p++) begin
      d = exp_d.pop_front();
      total++;
      if (a_rdata[p*32 +: 32] !== d[31:0]) begin
        bad++;
        $display("FAIL %s rdata%0d got=%h exp=%h", name, p, a_rdata[p*32 +: 32], d[31:0]);
      end
    end
    b = exp_b.pop_front();
    total++;
    if (a_rbusy !== b[1:0]) begin
      bad++;
      $display("FAIL %s rbusy got=%b exp=%b", name, a_rbusy, b[1:0]);
    end
  endtask

  task automatic test_reset;
    rst = 1; idle_a();
    b_we1 = 0; b_sb_set = 0; b_waddr1 = 0; b_sb_addr = 0; b_wdata1 = 0; b_raddr = 0;
    c_we0 = 0; c_we1 = 0; c_sb_set = 0; c_waddr0 = 0; c_waddr1 = 0; c_sb_addr = 0;
    c_wdata0 = 0; c_wdata1 = 0; c_raddr = 0; a_raddr = 0;
    tick(); tick();
    rst = 0;
    for (int i = 0; i < 32; i++) begin
      a_raddr = {i[4:0], 5'(31 - i)};
      check_a("reset_read", 32'd0, 32'd0, 2'b00);
    end
    // write issued while reset is high must be discarded
    tick();
    a_we0 = 1; a_waddr0 = 7; a_wdata0 = 32'hCAFE0007; a_sb_set = 1; a_sb_addr = 7;
    rst = 1;
    tick();
    rst = 0; idle_a();
    a_raddr = {5'd7, 5'd7};
    check_a("reset_over_we0", 32'd0, 32'd0, 2'b00);
  endtask

  task automatic test_bypass;
    tick();
    a_we0 = 1; a_waddr0 = 5; a_wdata0 = 32'hDEADBEEF; a_raddr = {5'd1, 5'd5};
    check_a("bypass_we0", 32'hDEADBEEF, 32'd0, 2'b00);
    tick(); idle_a();
    check_a("stored_we0", 32'hDEADBEEF, 32'd0, 2'b00);
  endtask

  task automatic test_dual_write;
    tick();
    a_we0 = 1; a_waddr0 = 9; a_wdata0 = 32'h11111111;
    a_we1 = 1; a_waddr1 = 9; a_wdata1 = 32'h22222222;
    a_raddr = {5'd9, 5'd9};
    check_a("collide_bypass", 32'h22222222, 32'h22222222, 2'b00);
    tick(); idle_a();
    check_a("collide_stored", 32'h22222222, 32'h22222222, 2'b00);
    a_we0 = 1; a_waddr0 = 3; a_wdata0 = 32'h33333333;
    a_we1 = 1; a_waddr1 = 4; a_wdata1 = 32'h44444444;
    a_raddr = {5'd4, 5'd3};
    check_a("split_bypass", 32'h33333333, 32'h44444444, 2'b00);
    tick(); idle_a();
    check_a("split_stored", 32'h33333333, 32'h44444444, 2'b00);
  endtask

  task automatic test_zero_reg;
    tick();
    a_we1 = 1; a_waddr1 = 0; a_wdata1 = 32'hFFFFFFFF; a_sb_set = 1; a_sb_addr = 0;
    a_raddr = {5'd0, 5'd0};
    b_we1 = 1; b_waddr1 = 0; b_wdata1 = 32'hFFFFFFFF; b_sb_set = 1; b_sb_addr = 0;
    b_raddr = {5'd0, 5'd0};
    check_a("zero_during", 32'd0, 32'd0, 2'b00);
    total++;
    if (b_rdata !== {2{32'hFFFFFFFF}}) begin
      bad++;
      $display("FAIL nozero_bypass got=%h exp=%h", b_rdata, {2{32'hFFFFFFFF}});
    end
    tick(); idle_a();
    b_we1 = 0; b_sb_set = 0;
    check_a("zero_after", 32'd0, 32'd0, 2'b00);
    total++;
    if (b_rdata !== {2{32'hFFFFFFFF}}) begin
      bad++;
      $display("FAIL nozero_stored got=%h exp=%h", b_rdata, {2{32'hFFFFFFFF}});
    end
    total++;
    if (b_rbusy !== 2'b11) begin
      bad++;
      $display("FAIL nozero_pending got=%b exp=11", b_rbusy);
    end
  endtask

  task automatic test_scoreboard;
    tick();
    a_sb_set = 1; a_sb_addr = 12; a_raddr = {5'd12, 5'd3};
    check_a("sb_before_edge", 32'h33333333, 32'd0, 2'b00);
    tick(); idle_a();
    check_a("sb_pending", 32'h33333333, 32'd0, 2'b10);
    a_raddr = {5'd12, 5'd12};
    a_we1 = 1; a_waddr1 = 12; a_wdata1 = 32'h0000C0DE;
    check_a("sb_clear_bypass", 32'h0000C0DE, 32'h0000C0DE, 2'b00);
    tick(); idle_a();
    check_a("sb_cleared", 32'h0000C0DE, 32'h0000C0DE, 2'b00);
    a_sb_set = 1; a_sb_addr = 12; a_we1 = 1; a_waddr1 = 12; a_wdata1 = 32'h0000BEEF;
    check_a("sb_set_we1_during", 32'h0000BEEF, 32'h0000BEEF, 2'b00);
    tick(); idle_a();
    check_a("sb_set_wins", 32'h0000BEEF, 32'h0000BEEF, 2'b11);
    a_we0 = 1; a_waddr0 = 12; a_wdata0 = 32'h00000A0A;
    tick(); idle_a();
    check_a("we0_keeps_pending", 32'h00000A0A, 32'h00000A0A, 2'b11);
  endtask

  task automatic test_random_wide;
    logic [63:0] m_reg [16];
    logic [15:0] m_pend;
    logic [63:0] d;
    logic [3:0]  b;
    logic [3:0]  ra;
    for (int i = 0; i < 16; i++) m_reg[i] = '0;
    m_pend = '0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      tick();
      c_we0 = 1'($urandom); c_waddr0 = 4'($urandom); c_wdata0 = {$urandom, $urandom};
      c_we1 = 1'($urandom); c_waddr1 = 4'($urandom); c_wdata1 = {$urandom, $urandom};
      c_sb_set = 1'($urandom); c_sb_addr = 4'($urandom);
      if (cyc % 3 == 0) c_waddr1 = c_sb_addr;
      if (cyc % 5 == 0) c_waddr0 = c_waddr1;
      c_raddr = 16'($urandom);
      if (cyc % 4 == 0) c_raddr[3:0] = c_waddr1;
      b = '0;
      for (int p = 0; p < 4; p++) begin
        ra = c_raddr[p*4 +: 4];
        d = m_reg[ra];
        if (c_we1 && c_waddr1 == ra)      d = c_wdata1;
        else if (c_we0 && c_waddr0 == ra) d = c_wdata0;
        b[p] = m_pend[ra] && !(c_we1 && c_waddr1 == ra);
        if (ra == 0) begin d = '0; b[p] = 1'b0; end
        exp_d.push_back(d);
      end
      exp_b.push_back(b);
      #1;
      for (int p = 0; p < 4; p++) begin
        d = exp_d.pop_front();
        total++;
        if (c_rdata[p*64 +: 64] !== d) begin
          bad++;
          $display("FAIL rand_rdata%0d cyc=%0d got=%h exp=%h", p, cyc, c_rdata[p*64 +: 64], d);
        end
      end
      b = exp_b.pop_front();
      total++;
      if (c_rbusy !== b) begin
        bad++;
        $display("FAIL rand_rbusy cyc=%0d got=%b exp=%b", cyc, c_rbusy, b);
      end
      if (c_we0) m_reg[c_waddr0] = c_wdata0;
      if (c_we1) m_reg[c_waddr1] = c_wdata1;
      if (c_we1) m_pend[c_waddr1] = 1'b0;
      if (c_sb_set) m_pend[c_sb_addr] = 1'b1;
      m_reg[0] = '0;
      m_pend[0] = 1'b0;
    end
    tick();
    c_we0 = 0; c_we1 = 0; c_sb_set = 0;
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_dual_write();
    test_zero_reg();
    test_scoreboard();
    test_random_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port register file, successor to the single-write/two-read CPU register file. It has N read ports and two write ports with defined priority. Reads are combinational with same-cycle write bypass, and register 0 can optionally be hardwired to zero. A per-register pending-write scoreboard lets the datapath detect load-use hazards without external tracking.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W registers
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never marked pending

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
we0  input  1  write enable, port 0 (ALU writeback)
waddr0  input  ADDR_W  write address, port 0
wdata0  input  DATA_W  write data, port 0
we1  input  1  write enable, port 1 (memory/late writeback); clears pending
waddr1  input  ADDR_W  write address, port 1
wdata1  input  DATA_W  write data, port 1
sb_set  input  1  mark sb_addr as pending-write
sb_addr  input  ADDR_W  register to mark pending
raddr  input  NUM_RD*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W]
rdata  output  NUM_RD*DATA_W  read data; port k at bits [k*DATA_W +: DATA_W]
rbusy  output  NUM_RD  port k's register has an outstanding pending write

Behaviour:
Reset:
- rst high at a clock edge sets all registers to 0 and clears all pending bits.
- rst overrides we0, we1 and sb_set in the same cycle.
- After reset, rdata is all 0 and rbusy is all 0.

Writes (rising edge, rst low):
- we0 writes wdata0 to waddr0.
- we1 writes wdata1 to waddr1.
- Both enabled to the same address: port 1 wins, port 0 is dropped.
- Different addresses: both writes commit.
- ZERO_REG=1: any write to address 0 is ignored.

Reads (combinational, zero latency):
- rdata_k = reg[raddr_k], then apply bypass in this order:
  - if we1 and waddr1==raddr_k, rdata_k = wdata1;
  - else if we0 and waddr0==raddr_k, rdata_k = wdata0.
- ZERO_REG=1 and raddr_k==0: rdata_k = 0 regardless of bypass.
- Bypass priority matches write priority, so the value read equals the value held after the edge.

Scoreboard (pending bit per register):
- On an edge with sb_set: pending[sb_addr] <= 1.
- On an edge with we1: pending[waddr1] <= 0.
- sb_set and we1 to the same address in the same cycle: set wins (a new producer was issued), pending stays 1.
- we0 does not affect pending bits.
- rbusy_k = pending[raddr_k] AND NOT (we1 AND waddr1==raddr_k), so a clearing write is bypassed the same cycle.
- ZERO_REG=1: rbusy_k = 0 whenever raddr_k==0, and sb_set to address 0 is ignored.

Misc:
- Read ports are fully independent; identical addresses on several ports are legal.
- No internal counters wrap; addresses are exactly ADDR_W bits, so no out-of-range case exists.

Test Plan:
1. Reset then read all 32 registers on both ports -> every rdata = 0, rbusy = 00. Apply rst mid-stream with we0=1 to reg 7 -> reg 7 still 0 afterwards.
2. we0 waddr0=5 wdata0=0xDEADBEEF, raddr0=5 in the same cycle -> rdata0 = 0xDEADBEEF before the edge (bypass) and after it (stored).
3. we0 and we1 both to reg 9 (0x11111111 / 0x22222222) -> rdata during the cycle = 0x22222222, and reg 9 = 0x22222222 afterwards. Repeat with we0 to reg 3 and we1 to reg 4 -> both written.
4. ZERO_REG=1: we1 to reg 0 with 0xFFFFFFFF, and sb_set to reg 0 -> rdata for reg 0 = 0, rbusy = 0. Rerun with ZERO_REG=0 -> reg 0 reads 0xFFFFFFFF.
5. sb_set reg 12 -> next cycle rbusy for raddr=12 is 1. we1 reg 12 -> rbusy drops to 0 in that same cycle (bypass), and pending is cleared afterwards. Simultaneous sb_set and we1 on reg 12 -> pending remains 1.
6. NUM_RD=4, DATA_W=64, ADDR_W=4: random write/read/sb sequence vs. scoreboard model -> all rdata and rbusy match the reference model every cycle.
